// File: rtl/noc_obuffer_pkt.sv
// noc_obuffer_pkt
// NoC egress output buffer. Wide input words, each packing FLITS_PER_WORD
// Avalon-ST sub-flits, are stored in a FIFO of DEPTH words. The sub-flits
// are then replayed one per cycle onto a DATA_WIDTH Avalon-ST source.
// The buffer runs either store-and-forward (CUT_THROUGH=0) or
// cut-through (CUT_THROUGH=1).
//
// Sub-flit layout, MSB to LSB: vld, sop, eop, empty, error, data.
// Sub-flit 0 sits in the MSBs of i_data and is emitted first.
//
// Ports
//   clk, reset    clock; asynchronous active-high reset
//   i_valid       input word valid
//   i_data        packed input word (WORD_W bits)
//   o_ready       input side ready (= !full)
//   o_valid       source valid
//   o_sop, o_eop  source packet framing
//   o_data        source payload
//   o_empty       source empty symbols
//   o_error       source error
//   i_ready       sink ready (ready latency 0)
//   o_pkt_count   number of complete packets (eop sub-flits) buffered
//   o_overflow    sticky: a word was offered while the buffer was full
//
// Handshakes: both sides use plain valid/ready. A word is written on any
// cycle with i_valid && o_ready. A sub-flit transfers on any cycle with
// o_valid && i_ready. While o_valid is high and i_ready is low, every
// source output holds its value. o_ready depends only on registered
// count, so there is no combinational path from the input side to any
// output.
module noc_obuffer_pkt #(
  parameter int DATA_WIDTH     = 64,
  parameter int EMPTY_WIDTH    = 3,
  parameter int FLITS_PER_WORD = 2,
  parameter int DEPTH          = 32,
  parameter int CUT_THROUGH    = 0,
  localparam int SUB_W         = DATA_WIDTH + EMPTY_WIDTH + 4,
  localparam int WORD_W        = FLITS_PER_WORD * SUB_W,
  localparam int PC_W          = $clog2(DEPTH * FLITS_PER_WORD) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_valid,
  input  logic [WORD_W-1:0]      i_data,
  output logic                   o_ready,
  output logic                   o_valid,
  output logic                   o_sop,
  output logic                   o_eop,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic [EMPTY_WIDTH-1:0] o_empty,
  output logic                   o_error,
  input  logic                   i_ready,
  output logic [PC_W-1:0]        o_pkt_count,
  output logic                   o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (FLITS_PER_WORD > 1) ? $clog2(FLITS_PER_WORD) : 1;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [SW-1:0]     sub_idx;
  logic [PC_W-1:0]   pkt_cnt;
  logic              overflow_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic              wr_en;
  logic [WORD_W-1:0] head_word;
  logic [SUB_W-1:0]  head_sub;
  logic              h_vld;
  logic              h_sop;
  logic              h_eop;
  logic [EMPTY_WIDTH-1:0] h_empty;
  logic              h_error;
  logic [DATA_WIDTH-1:0]  h_data;
  logic              bypass;
  logic              release_ok;
  logic              discard;
  logic              emit;
  logic              consume;
  logic              last_sub;
  logic              pop;
  logic [PC_W-1:0]   eop_in;
  logic [PC_W-1:0]   pkt_inc;
  logic              pkt_dec;

  assign fifo_full  = (count == CW'(DEPTH));
  assign fifo_empty = (count == '0);
  assign wr_en      = i_valid && !fifo_full;

  // Head sub-flit select: sub_idx walks the head word from the MSB end.
  assign head_word = mem[rd_ptr];

  always_comb begin
    head_sub = '0;
    for (int k = 0; k < FLITS_PER_WORD; k++) begin
      if (sub_idx == SW'(k)) head_sub = head_word[WORD_W-1-k*SUB_W -: SUB_W];
    end
  end

  assign h_vld   = head_sub[SUB_W-1];
  assign h_sop   = head_sub[SUB_W-2];
  assign h_eop   = head_sub[SUB_W-3];
  assign h_empty = head_sub[SUB_W-4 -: EMPTY_WIDTH];
  assign h_error = head_sub[DATA_WIDTH];
  assign h_data  = head_sub[DATA_WIDTH-1:0];

  // In store-and-forward mode a packet longer than the buffer would never
  // see its eop arrive. Once the buffer is full with no complete packet
  // inside, draining starts anyway so the upstream can make progress.
  assign bypass     = fifo_full && (pkt_cnt == '0);
  assign release_ok = (CUT_THROUGH != 0) || (pkt_cnt != '0) || bypass;

  // A vld=0 slot is dropped in one cycle without waiting for the sink.
  assign discard  = !fifo_empty && !h_vld;
  assign emit     = !fifo_empty && h_vld && release_ok;
  assign consume  = discard || (emit && i_ready);
  assign last_sub = (sub_idx == SW'(FLITS_PER_WORD - 1));
  assign pop      = consume && last_sub;

  // Count the complete packets that arrive with this word.
  always_comb begin
    eop_in = '0;
    for (int k = 0; k < FLITS_PER_WORD; k++) begin
      if (i_data[WORD_W-1-k*SUB_W] && i_data[WORD_W-3-k*SUB_W]) begin
        eop_in = eop_in + PC_W'(1);
      end
    end
  end

  assign pkt_inc = wr_en ? eop_in : '0;
  assign pkt_dec = emit && i_ready && h_eop;

  // Storage array: no reset, so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      sub_idx    <= '0;
      pkt_cnt    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (consume) sub_idx <= last_sub ? '0 : sub_idx + SW'(1);
      pkt_cnt <= pkt_cnt + pkt_inc - PC_W'(pkt_dec);
      if (i_valid && fifo_full) overflow_q <= 1'b1;
    end
  end

  assign o_ready     = !fifo_full;
  assign o_valid     = emit;
  assign o_sop       = emit && h_sop;
  assign o_eop       = emit && h_eop;
  assign o_empty     = emit ? h_empty : '0;
  assign o_error     = emit && h_error;
  assign o_data      = emit ? h_data : '0;
  assign o_pkt_count = pkt_cnt;
  assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_noc_obuffer_pkt.sv
// Directed bench for noc_obuffer_pkt. Two instances share the sink ready
// and the input data: u_sf is store-and-forward and u_ct is cut-through.
// Both have DEPTH=4 and two sub-flits per word. A per-cycle schedule
// drives the words and lists the expected valid/ready/pkt_count. A
// negedge monitor compares every transferred beat against an
// expected-beat queue.
module tb_noc_obuffer_pkt;

  localparam int DW   = 64;
  localparam int EW   = 3;
  localparam int FPW  = 2;
  localparam int DEP  = 4;
  localparam int SUBW = DW + EW + 4;
  localparam int WW   = FPW * SUBW;
  localparam int PCW  = $clog2(DEP * FPW) + 1;
  localparam int BW   = SUBW - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          v_sf = 1'b0;
  logic          v_ct = 1'b0;
  logic [WW-1:0] i_data = '0;
  logic          i_ready = 1'b1;

  logic sf_o_ready, sf_o_valid, sf_o_sop, sf_o_eop, sf_o_error, sf_o_overflow;
  logic [DW-1:0]  sf_o_data;
  logic [EW-1:0]  sf_o_empty;
  logic [PCW-1:0] sf_o_pkt_count;
  logic ct_o_ready, ct_o_valid, ct_o_sop, ct_o_eop, ct_o_error, ct_o_overflow;
  logic [DW-1:0]  ct_o_data;
  logic [EW-1:0]  ct_o_empty;
  logic [PCW-1:0] ct_o_pkt_count;

  noc_obuffer_pkt #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .FLITS_PER_WORD(FPW),
                    .DEPTH(DEP), .CUT_THROUGH(0)) u_sf (
    .clk(clk), .reset(reset), .i_valid(v_sf), .i_data(i_data),
    .o_ready(sf_o_ready), .o_valid(sf_o_valid), .o_sop(sf_o_sop),
    .o_eop(sf_o_eop), .o_data(sf_o_data), .o_empty(sf_o_empty),
    .o_error(sf_o_error), .i_ready(i_ready), .o_pkt_count(sf_o_pkt_count),
    .o_overflow(sf_o_overflow)
  );

  noc_obuffer_pkt #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .FLITS_PER_WORD(FPW),
                    .DEPTH(DEP), .CUT_THROUGH(1)) u_ct (
    .clk(clk), .reset(reset), .i_valid(v_ct), .i_data(i_data),
    .o_ready(ct_o_ready), .o_valid(ct_o_valid), .o_sop(ct_o_sop),
    .o_eop(ct_o_eop), .o_data(ct_o_data), .o_empty(ct_o_empty),
    .o_error(ct_o_error), .i_ready(i_ready), .o_pkt_count(ct_o_pkt_count),
    .o_overflow(ct_o_overflow)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int sf_beats = 0;
  int ct_beats = 0;
  logic [BW-1:0] exp_sf_q[$];
  logic [BW-1:0] exp_ct_q[$];
  logic [BW-1:0] sf_e, ct_e;
  logic [BW-1:0] sf_beat, ct_beat;

  assign sf_beat = {sf_o_sop, sf_o_eop, sf_o_empty, sf_o_error, sf_o_data};
  assign ct_beat = {ct_o_sop, ct_o_eop, ct_o_empty, ct_o_error, ct_o_data};

  task automatic check_eq(input string tag, input logic [127:0] obs,
                          input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Inputs only change just after posedge, so a beat seen here is the one
  // the next posedge transfers.
  always @(negedge clk) begin
    if (!reset && sf_o_valid && i_ready) begin
      sf_beats++;
      check_eq("sf_beat_expected", 128'(exp_sf_q.size() != 0), 128'(1));
      if (exp_sf_q.size() != 0) begin
        sf_e = exp_sf_q.pop_front();
        check_eq("sf_beat", 128'(sf_beat), 128'(sf_e));
      end
    end
    if (!reset && ct_o_valid && i_ready) begin
      ct_beats++;
      check_eq("ct_beat_expected", 128'(exp_ct_q.size() != 0), 128'(1));
      if (exp_ct_q.size() != 0) begin
        ct_e = exp_ct_q.pop_front();
        check_eq("ct_beat", 128'(ct_beat), 128'(ct_e));
      end
    end
  end

  // ---------------- driver helpers ----------------
  function automatic logic [SUBW-1:0] mk(input logic vld, input logic sop,
      input logic eop, input logic [EW-1:0] emp, input logic err,
      input logic [DW-1:0] d);
    return {vld, sop, eop, emp, err, d};
  endfunction

  task automatic push_exp(input logic [SUBW-1:0] s, input bit to_sf, input bit to_ct);
    if (to_sf) exp_sf_q.push_back(s[BW-1:0]);
    if (to_ct) exp_ct_q.push_back(s[BW-1:0]);
  endtask

  logic [WW-1:0] sch_d [16];
  bit            sch_v [16];
  bit            pat_sfv [16];
  bit            pat_ctv [16];
  bit            pat_rdy [16];
  int            pat_pc [16];
  bit            use_ct;

  // Runs n cycles of the schedule; entered and left just after a posedge.
  task automatic run_sched(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      v_sf   = sch_v[c];
      v_ct   = sch_v[c] && use_ct;
      i_data = sch_d[c];
      @(negedge clk);
      check_eq($sformatf("%s_sf_valid_c%0d", tag, c), 128'(sf_o_valid), 128'(pat_sfv[c]));
      check_eq($sformatf("%s_sf_ready_c%0d", tag, c), 128'(sf_o_ready), 128'(pat_rdy[c]));
      check_eq($sformatf("%s_sf_pkts_c%0d", tag, c), 128'(sf_o_pkt_count), 128'(pat_pc[c]));
      if (use_ct) check_eq($sformatf("%s_ct_valid_c%0d", tag, c), 128'(ct_o_valid), 128'(pat_ctv[c]));
      @(posedge clk); #1;
    end
    v_sf = 1'b0;
    v_ct = 1'b0;
  endtask

  task automatic write_sf(input logic [WW-1:0] w);
    bit acc = 1'b0;
    bit rdy;
    v_sf   = 1'b1;
    i_data = w;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      rdy = sf_o_ready;
      @(posedge clk); #1;
      acc = rdy;
    end
    v_sf = 1'b0;
    check_eq("sf_write_accepted", 128'(acc), 128'(1));
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (exp_sf_q.size() == 0 && exp_ct_q.size() == 0) break;
      @(posedge clk); #1;
    end
    repeat (3) begin @(posedge clk); #1; end
    check_eq({tag, "_sf_left"}, 128'(exp_sf_q.size()), 128'(0));
    check_eq({tag, "_ct_left"}, 128'(exp_ct_q.size()), 128'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    v_sf = 1'b0;
    v_ct = 1'b0;
    i_ready = 1'b1;
    exp_sf_q.delete();
    exp_ct_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [SUBW-1:0] s [12];
  logic [WW-1:0]   w4;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    // Reset state, sampled while reset is held.
    @(negedge clk);
    check_eq("rst_valid", 128'(sf_o_valid), 128'(0));
    check_eq("rst_ready", 128'(sf_o_ready), 128'(1));
    check_eq("rst_pkts", 128'(sf_o_pkt_count), 128'(0));
    check_eq("rst_ovf", 128'(sf_o_overflow), 128'(0));
    check_eq("rst_data", 128'(sf_beat), 128'(0));
    check_eq("rst_ct_valid", 128'(ct_o_valid), 128'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // T1: one 2-flit packet in one word.
    use_ct = 1'b1;
    s[0] = mk(1, 1, 0, 3'd0, 0, 64'h1111_0000_0000_0001);
    s[1] = mk(1, 0, 1, 3'd5, 1, 64'h1111_0000_0000_0002);
    sch_v = '{1,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
    sch_d = '{default: '0};
    sch_d[0] = {s[0], s[1]};
    pat_sfv = '{0,1,1,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
    pat_ctv = '{0,1,1,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
    pat_rdy = '{default: 1};
    pat_pc  = '{0,1,1,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
    push_exp(s[0], 1, 1);
    push_exp(s[1], 1, 1);
    run_sched("t1", 4);
    wait_drain("t1");
    check_eq("t1_no_ovf", 128'(sf_o_overflow), 128'(0));

    // T2: 6-flit packet over 3 words with 2-cycle gaps.
    do_reset();
    for (int k = 0; k < 6; k++) s[k] = mk(1, k == 0, k == 5, (k == 5) ? 3'd2 : 3'd0, 0, 64'h2222_0000_0000_0000 + 64'(k));
    sch_v = '{1,0,0,1, 0,0,1,0, 0,0,0,0, 0,0,0,0};
    sch_d = '{default: '0};
    sch_d[0] = {s[0], s[1]};
    sch_d[3] = {s[2], s[3]};
    sch_d[6] = {s[4], s[5]};
    pat_sfv = '{0,0,0,0, 0,0,0,1, 1,1,1,1, 1,0,0,0};
    pat_ctv = '{0,1,1,0, 1,1,0,1, 1,0,0,0, 0,0,0,0};
    pat_rdy = '{default: 1};
    pat_pc  = '{0,0,0,0, 0,0,0,1, 1,1,1,1, 1,0,0,0};
    for (int k = 0; k < 6; k++) push_exp(s[k], 1, 1);
    run_sched("t2", 14);
    wait_drain("t2");

    // T3: second word's sub-flit 1 is an invalid slot.
    do_reset();
    s[0] = mk(1, 1, 0, 3'd0, 0, 64'h3333_0000_0000_0001);
    s[1] = mk(1, 0, 0, 3'd0, 0, 64'h3333_0000_0000_0002);
    s[2] = mk(1, 0, 0, 3'd0, 0, 64'h3333_0000_0000_0003);
    s[3] = mk(0, 1, 1, 3'd7, 1, 64'hDEAD_BEEF_DEAD_BEEF);
    s[4] = mk(1, 0, 0, 3'd0, 0, 64'h3333_0000_0000_0005);
    s[5] = mk(1, 0, 1, 3'd1, 0, 64'h3333_0000_0000_0006);
    sch_v = '{1,1,1,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
    sch_d = '{default: '0};
    sch_d[0] = {s[0], s[1]};
    sch_d[1] = {s[2], s[3]};
    sch_d[2] = {s[4], s[5]};
    pat_sfv = '{0,0,0,1, 1,1,0,1, 1,0,0,0, 0,0,0,0};
    pat_ctv = '{0,1,1,1, 0,1,1,0, 0,0,0,0, 0,0,0,0};
    pat_rdy = '{default: 1};
    pat_pc  = '{0,0,0,1, 1,1,1,1, 1,0,0,0, 0,0,0,0};
    for (int k = 0; k < 6; k++) if (k != 3) push_exp(s[k], 1, 1);
    run_sched("t3", 10);
    wait_drain("t3");
    check_eq("t3_no_ovf", 128'(sf_o_overflow), 128'(0));

    // T4: store-and-forward, 12-flit packet whose eop only arrives after
    // the buffer has filled; the full-buffer bypass must start the drain.
    do_reset();
    use_ct = 1'b0;
    for (int k = 0; k < 12; k++) s[k] = mk(1, k == 0, k == 11, 3'd0, 0, 64'h4444_0000_0000_0000 + 64'(k));
    sch_v = '{1,1,1,1, 0,0,0,0, 0,0,0,0, 0,0,0,0};
    sch_d = '{default: '0};
    for (int k = 0; k < 4; k++) sch_d[k] = {s[2*k], s[2*k+1]};
    pat_sfv = '{0,0,0,0, 1,1,0,0, 0,0,0,0, 0,0,0,0};
    pat_ctv = '{default: 0};
    pat_rdy = '{1,1,1,1, 0,0,1,1, 1,1,1,1, 1,1,1,1};
    pat_pc  = '{default: 0};
    for (int k = 0; k < 12; k++) push_exp(s[k], 1, 0);
    run_sched("t4", 7);
    write_sf({s[8], s[9]});
    write_sf({s[10], s[11]});
    wait_drain("t4");

    // T5: sink stalled, buffer filled, one extra word offered.
    do_reset();
    use_ct = 1'b1;
    i_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s[2*k]   = mk(1, 1, 0, 3'd0, 0, 64'h5555_0000_0000_0000 + 64'(2*k));
      s[2*k+1] = mk(1, 0, 1, 3'(k), 0, 64'h5555_0000_0000_0000 + 64'(2*k+1));
    end
    sch_v = '{1,1,1,1, 1,0,0,0, 0,0,0,0, 0,0,0,0};
    sch_d = '{default: '0};
    for (int k = 0; k < 4; k++) sch_d[k] = {s[2*k], s[2*k+1]};
    sch_d[4] = {mk(1, 1, 0, 3'd0, 0, 64'hEEEE_EEEE_EEEE_EEEE), mk(1, 0, 1, 3'd0, 0, 64'hEEEE_EEEE_EEEE_EEEF)};
    pat_sfv = '{0,1,1,1, 1,1,1,0, 0,0,0,0, 0,0,0,0};
    pat_ctv = '{0,1,1,1, 1,1,1,0, 0,0,0,0, 0,0,0,0};
    pat_rdy = '{1,1,1,1, 0,0,0,0, 0,0,0,0, 0,0,0,0};
    pat_pc  = '{0,1,2,3, 4,4,4,0, 0,0,0,0, 0,0,0,0};
    for (int k = 0; k < 8; k++) push_exp(s[k], 1, 1);
    run_sched("t5", 7);
    @(negedge clk);
    check_eq("t5_sf_ovf", 128'(sf_o_overflow), 128'(1));
    check_eq("t5_ct_ovf", 128'(ct_o_overflow), 128'(1));
    check_eq("t5_sf_hold", 128'(sf_beat), 128'(s[0][BW-1:0]));
    check_eq("t5_ct_hold", 128'(ct_beat), 128'(s[0][BW-1:0]));
    @(posedge clk); #1;
    sf_beats = 0;
    ct_beats = 0;
    i_ready = 1'b1;
    wait_drain("t5");
    check_eq("t5_sf_beats", 128'(sf_beats), 128'(DEP * FPW));
    check_eq("t5_ct_beats", 128'(ct_beats), 128'(DEP * FPW));
    check_eq("t5_ovf_sticky", 128'(sf_o_overflow), 128'(1));

    // T6: asynchronous reset while a packet is draining.
    s[0] = mk(1, 1, 0, 3'd0, 0, 64'h6666_0000_0000_0000);
    s[1] = mk(1, 0, 1, 3'd3, 1, 64'h6666_0000_0000_0001);
    s[2] = mk(1, 1, 0, 3'd0, 0, 64'h6666_0000_0000_0002);
    s[3] = mk(1, 0, 1, 3'd4, 0, 64'h6666_0000_0000_0003);
    sch_v = '{1,1,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
    sch_d = '{default: '0};
    sch_d[0] = {s[0], s[1]};
    sch_d[1] = {s[2], s[3]};
    pat_sfv = '{0,1,1,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
    pat_ctv = '{0,1,1,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
    pat_rdy = '{default: 1};
    pat_pc  = '{0,1,2,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
    for (int k = 0; k < 4; k++) push_exp(s[k], 1, 1);
    run_sched("t6", 3);
    @(negedge clk);
    check_eq("t6_pre_valid", 128'(sf_o_valid), 128'(1));
    #2;
    reset = 1'b1;
    #1;
    check_eq("t6_rst_sf_valid", 128'(sf_o_valid), 128'(0));
    check_eq("t6_rst_sf_fields", 128'(sf_beat), 128'(0));
    check_eq("t6_rst_ct_valid", 128'(ct_o_valid), 128'(0));
    check_eq("t6_rst_ct_fields", 128'(ct_beat), 128'(0));
    check_eq("t6_rst_pkts", 128'(sf_o_pkt_count), 128'(0));
    check_eq("t6_rst_ovf", 128'(sf_o_overflow), 128'(0));
    check_eq("t6_rst_ready", 128'(sf_o_ready), 128'(1));
    exp_sf_q.delete();
    exp_ct_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
